// File: rtl/divider_pkg.sv
// Shared definitions for the sequential arithmetic blocks (multipliers and divider):
// control FSM state encoding, operation-type codes and iteration-count helpers.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } ctl_state_t;

  // Operation type encodings shared with the multiplier family
  localparam logic [1:0] MUL_TYPE_UNSIGNED = 2'd0;
  localparam logic [1:0] MUL_TYPE_SIGNED   = 2'd1;
  localparam logic [1:0] MUL_TYPE_MIXED    = 2'd2;
  localparam logic [1:0] OP_TYPE_DIVIDE    = 2'd3;

  // Handshake levels: trigger is sampled high, ready/done are asserted high
  localparam logic TRIGGER_ACTIVE = 1'b1;
  localparam logic READY_ACTIVE   = 1'b1;

  function automatic int iter_count(input int c_width, input int fixed_point);
    return c_width + fixed_point;
  endfunction

endpackage

// File: rtl/divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the
// divisor and keep the difference only when it is non-negative.
module div_step #(
  parameter int C_WIDTH = 8
) (
  input  logic [C_WIDTH:0]   rem,
  input  logic               dbit,
  input  logic [C_WIDTH-1:0] divisor,
  output logic [C_WIDTH:0]   rem_next,
  output logic               qbit
);

  logic [C_WIDTH+1:0] shifted;
  logic [C_WIDTH+1:0] diff;

  // The partial remainder is always below the divisor, so the kept value fits C_WIDTH+1 bits
  always_comb begin
    shifted  = {rem, dbit};
    diff     = shifted - {2'b00, divisor};
    qbit     = (shifted >= {2'b00, divisor});
    rem_next = (C_WIDTH + 1)'(qbit ? diff : shifted);
  end

endmodule

// File: rtl/divider.sv
// Sequential unsigned fixed-point divider: y = (a << FIXED_POINT) / b with remainder,
// one quotient bit per clock, using the trigger/ready/done handshake of the multipliers.
module divider
  import divider_pkg::*;
#(
  parameter int C_WIDTH     = 8,
  parameter int FIXED_POINT = 0
) (
  input  logic               ctl_clk,
  input  logic               reset,
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
  input  logic               trigger,
  output logic [C_WIDTH-1:0] y,
  output logic [C_WIDTH-1:0] r,
  output logic               ready,
  output logic               done,
  output logic               div_by_zero,
  output logic               ovf
);

  localparam int N  = iter_count(C_WIDTH, FIXED_POINT);
  localparam int CW = $clog2(N + 1);

  ctl_state_t         state_reg;
  logic [C_WIDTH-1:0] a_reg;
  logic [C_WIDTH-1:0] b_reg;
  logic [N-1:0]       dvd_reg;
  logic [N-2:0]       q_reg;
  logic [C_WIDTH:0]   rem_reg;
  logic [CW-1:0]      cnt_reg;

  logic [C_WIDTH:0]   rem_next;
  logic               qbit;
  logic [N-1:0]       q_final;
  logic               ovf_hit;

  div_step #(.C_WIDTH(C_WIDTH)) u_step (
    .rem      (rem_reg),
    .dbit     (dvd_reg[N-1]),
    .divisor  (b_reg),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  assign q_final = {q_reg, qbit};
  assign ovf_hit = ((q_final >> C_WIDTH) != '0);

  assign ready = (state_reg == IDLE);
  assign done  = (state_reg == DONE);

  always_ff @(posedge ctl_clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      dvd_reg     <= '0;
      q_reg       <= '0;
      rem_reg     <= '0;
      cnt_reg     <= '0;
      y           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (trigger == TRIGGER_ACTIVE) begin
            a_reg       <= a;
            b_reg       <= b;
            dvd_reg     <= N'(a) << FIXED_POINT;
            q_reg       <= '0;
            rem_reg     <= '0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
            state_reg   <= CALC;
            // A zero divisor takes a single pass so its done lands one edge after acceptance
            cnt_reg     <= (b == '0) ? CW'(1) : CW'(N);
          end
        end
        CALC: begin
          rem_reg <= rem_next;
          q_reg   <= q_final[N-2:0];
          dvd_reg <= {dvd_reg[N-2:0], 1'b0};
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_reg <= DONE;
            if (b_reg == '0) begin
              y           <= '1;
              r           <= a_reg;
              div_by_zero <= 1'b1;
            end else if (ovf_hit) begin
              y   <= '1;
              r   <= rem_next[C_WIDTH-1:0];
              ovf <= 1'b1;
            end else begin
              y <= q_final[C_WIDTH-1:0];
              r <= rem_next[C_WIDTH-1:0];
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
